pipeline_hazard_controller: RTL

Central sequencing block for the 5-stage pipeline.
- Generates the per-register stall/flush controls for IF_ID, ID_EX, EX_MEM and MEM_WB, plus the PC write enable.
- Resolves load-use hazards, branch/jump redirects, instruction- and data-memory wait cycles, and halt.
- Sits beside the datapath: consumes decoded stage fields and memory ready flags, drives only control.
- Also keeps 16-bit performance counters for stall cycles and redirects.

---
 rtl/pipeline_hazard_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing control for the 5-stage pipeline: per-register stall/flush,
// PC load enable and redirect source, halt tracking and saturating perf counters.
module pipeline_hazard_controller #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       rs_ID,
  input  logic [1:0]       rt_ID,
  input  logic             use_rs_ID,
  input  logic             use_rt_ID,
  input  logic             d_readM_EX,
  input  logic             RegWrite_EX,
  input  logic [1:0]       write_reg_addr_EX,
  input  logic             mispredict_EX,
  input  logic             jump_ID,
  input  logic             i_ready,
  input  logic             d_req_MEM,
  input  logic             d_ready,
  input  logic             is_halted_WB,
  output logic             pc_write,
  output logic [1:0]       redirect_sel,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             flush_EX_MEM,
  output logic             flush_MEM_WB,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_squash, w_squash_nxt;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_cnt, r_redir_cnt;

  logic w_halt_trig, w_dwait, w_loaduse, w_redirect, w_count_stall;

  assign w_halt_trig = (r_state == HALT) | is_halted_WB;
  assign w_dwait     = d_req_MEM & ~d_ready;
  assign w_loaduse   = d_readM_EX & RegWrite_EX &
                       ((use_rs_ID & (rs_ID == write_reg_addr_EX)) |
                        (use_rt_ID & (rt_ID == write_reg_addr_EX)));

  always_comb begin
    pc_write     = 1'b0;
    redirect_sel = 2'd0;
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_MEM = 1'b0;
    stall_MEM_WB = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    flush_MEM_WB = 1'b0;
    w_redirect   = 1'b0;
    w_state_nxt  = RUN;
    w_squash_nxt = r_squash;
    if (reset_n) begin
      if (w_halt_trig) begin
        {stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB} = '1;
        w_state_nxt = HALT;
      end else if (w_dwait) begin
        // EX is frozen here, so a pending mispredict is simply seen again on release.
        {stall_IF_ID, stall_ID_EX, stall_EX_MEM} = '1;
        flush_MEM_WB = 1'b1;
        w_state_nxt  = DWAIT;
      end else if (mispredict_EX) begin
        flush_IF_ID  = 1'b1;
        flush_ID_EX  = 1'b1;
        pc_write     = 1'b1;
        redirect_sel = 2'd1;
        w_redirect   = 1'b1;
        if (!i_ready) w_squash_nxt = 1'b1;
      end else if (w_loaduse) begin
        stall_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (jump_ID) begin
        flush_IF_ID  = 1'b1;
        pc_write     = 1'b1;
        redirect_sel = 2'd2;
        w_redirect   = 1'b1;
        if (!i_ready) w_squash_nxt = 1'b1;
      end else if (!i_ready) begin
        flush_IF_ID = 1'b1;
      end else if (r_squash) begin
        flush_IF_ID  = 1'b1;
        w_squash_nxt = 1'b0;
      end else begin
        pc_write = 1'b1;
      end
    end
  end

  assign w_count_stall = ~pc_write & ~w_halt_trig;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_squash    <= 1'b0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
      if (w_halt_trig) r_halted <= 1'b1;
      if (w_count_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect && (r_redir_cnt != '1)) r_redir_cnt <= r_redir_cnt + 1'b1;
    end
  end

  assign halted         = r_halted;
  assign stall_cycles   = r_stall_cnt;
  assign redirect_count = r_redir_cnt;

endmodule
